// File: rtl/branch_ctrl.sv
// Branch/jump sequencing controller: evaluates one control transfer at a time through the
// external comparator, then issues done/redirect followed by an optional flush window.
module branch_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_pc,
   input  logic [31:0]      req_imm,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [2:0]       req_fun3,
   input  logic             req_jal,
   input  logic             req_jalr,
   output logic [31:0]      cmp_A,
   output logic [31:0]      cmp_B,
   output logic             cmp_enb,
   output logic [2:0]       cmp_fun3,
   input  logic             cmp_res,
   output logic             done,
   output logic             taken,
   output logic [31:0]      link_data,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic             err,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int FLOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

   typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_RESOLVE, ST_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]        fun3_q, fun3_d;
   logic              jal_q, jal_d, jalr_q, jalr_d;
   logic              req_ready_q, req_ready_d;
   logic              cmp_enb_q, cmp_enb_d;
   logic              done_q, done_d, taken_q, taken_d, err_q, err_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [31:0]       redirect_pc_q, redirect_pc_d, link_data_q, link_data_d;
   logic              flush_q, flush_d;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

   logic              accept;
   logic              illegal;
   logic              taken_r;
   logic [31:0]       target;

   assign accept = req_valid && req_ready_q;

   // Funct3 legality only matters for conditional branches; jumps ignore funct3.
   assign illegal = !jal_q && !jalr_q && !fun3_q[2] && fun3_q[1];
   assign taken_r = (jal_q || jalr_q) ? 1'b1 : (illegal ? 1'b0 : cmp_res);
   assign target  = (jalr_q && !jal_q) ? ((rs1_q + imm_q) & ~32'd1) : (pc_q + imm_q);

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      imm_d            = imm_q;
      rs1_d            = rs1_q;
      rs2_d            = rs2_q;
      fun3_d           = fun3_q;
      jal_d            = jal_q;
      jalr_d           = jalr_q;
      req_ready_d      = req_ready_q;
      cmp_enb_d        = 1'b0;
      done_d           = 1'b0;
      taken_d          = 1'b0;
      err_d            = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      link_data_d      = link_data_q;
      flush_d          = flush_q;
      flush_cnt_d      = flush_cnt_q;
      taken_cnt_d      = taken_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               pc_d        = req_pc;
               imm_d       = req_imm;
               rs1_d       = req_rs1;
               rs2_d       = req_rs2;
               fun3_d      = req_fun3;
               jal_d       = req_jal;
               jalr_d      = req_jalr;
               cmp_enb_d   = !req_jal && !req_jalr && (req_fun3[2] || !req_fun3[1]);
               req_ready_d = 1'b0;
               state_d     = ST_EVAL;
            end
         end
         // Resolution outputs are computed here so they appear registered during RESOLVE.
         ST_EVAL: begin
            done_d           = 1'b1;
            taken_d          = taken_r;
            err_d            = illegal || (taken_r && target[1]);
            redirect_valid_d = taken_r && !target[1];
            redirect_pc_d    = target;
            link_data_d      = pc_q + 32'd4;
            if (taken_r && !target[1] && !(&taken_cnt_q))
               taken_cnt_d = taken_cnt_q + 1'b1;
            state_d          = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            if (redirect_valid_q && (FLUSH_CYCLES > 0)) begin
               flush_d     = 1'b1;
               flush_cnt_d = FC_W'(FLOAD);
               state_d     = ST_FLUSH;
            end else begin
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == '0) begin
               flush_d     = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end
         default: begin
            flush_d     = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         pc_q             <= '0;
         imm_q            <= '0;
         rs1_q            <= '0;
         rs2_q            <= '0;
         fun3_q           <= '0;
         jal_q            <= 1'b0;
         jalr_q           <= 1'b0;
         req_ready_q      <= 1'b1;
         cmp_enb_q        <= 1'b0;
         done_q           <= 1'b0;
         taken_q          <= 1'b0;
         err_q            <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         link_data_q      <= '0;
         flush_q          <= 1'b0;
         flush_cnt_q      <= '0;
         taken_cnt_q      <= '0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         imm_q            <= imm_d;
         rs1_q            <= rs1_d;
         rs2_q            <= rs2_d;
         fun3_q           <= fun3_d;
         jal_q            <= jal_d;
         jalr_q           <= jalr_d;
         req_ready_q      <= req_ready_d;
         cmp_enb_q        <= cmp_enb_d;
         done_q           <= done_d;
         taken_q          <= taken_d;
         err_q            <= err_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         link_data_q      <= link_data_d;
         flush_q          <= flush_d;
         flush_cnt_q      <= flush_cnt_d;
         taken_cnt_q      <= taken_cnt_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign cmp_A          = rs1_q;
   assign cmp_B          = rs2_q;
   assign cmp_fun3       = fun3_q;
   assign cmp_enb        = cmp_enb_q;
   assign done           = done_q;
   assign taken          = taken_q;
   assign err            = err_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign link_data      = link_data_q;
   assign flush          = flush_q;
   assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed requests, queue-based scoreboard, reset and saturation cases.
module tb_branch_ctrl;
   localparam int F = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_ready, req_jal, req_jalr;
   logic [31:0] req_pc, req_imm, req_rs1, req_rs2;
   logic [2:0]  req_fun3;
   logic [31:0] cmp_A, cmp_B, link_data, redirect_pc;
   logic        cmp_enb, cmp_res, done, taken, redirect_valid, flush, err;
   logic [2:0]  cmp_fun3;
   logic [15:0] taken_cnt;

   logic        s_req_valid, s_req_ready, s_req_jal;
   logic [31:0] s_req_pc, s_req_imm;
   logic [31:0] s_cmp_A, s_cmp_B, s_link_data, s_redirect_pc;
   logic        s_cmp_enb, s_cmp_res, s_done, s_taken, s_redirect_valid, s_flush, s_err;
   logic [2:0]  s_cmp_fun3;
   logic [1:0]  s_taken_cnt;

   typedef struct packed {
      logic        taken;
      logic        err;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] link;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic cmp_model(input logic enb, input logic [2:0] f,
                                      input logic [31:0] a, input logic [31:0] b);
      logic r;
      case (f)
         3'b000:  r = (a == b);
         3'b001:  r = (a != b);
         3'b100:  r = ($signed(a) <  $signed(b));
         3'b101:  r = ($signed(a) >= $signed(b));
         3'b110:  r = (a <  b);
         3'b111:  r = (a >= b);
         default: r = 1'b0;
      endcase
      return enb & r;
   endfunction

   assign cmp_res   = cmp_model(cmp_enb, cmp_fun3, cmp_A, cmp_B);
   assign s_cmp_res = cmp_model(s_cmp_enb, s_cmp_fun3, s_cmp_A, s_cmp_B);

   branch_ctrl #(.FLUSH_CYCLES(F), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_imm(req_imm),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_fun3(req_fun3), .req_jal(req_jal),
      .req_jalr(req_jalr), .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_enb(cmp_enb),
      .cmp_fun3(cmp_fun3), .cmp_res(cmp_res), .done(done), .taken(taken),
      .link_data(link_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .err(err), .taken_cnt(taken_cnt)
   );

   branch_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_pc(s_req_pc), .req_imm(s_req_imm),
      .req_rs1(32'd0), .req_rs2(32'd0), .req_fun3(3'b000), .req_jal(s_req_jal),
      .req_jalr(1'b0), .cmp_A(s_cmp_A), .cmp_B(s_cmp_B), .cmp_enb(s_cmp_enb),
      .cmp_fun3(s_cmp_fun3), .cmp_res(s_cmp_res), .done(s_done), .taken(s_taken),
      .link_data(s_link_data), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
      .flush(s_flush), .err(s_err), .taken_cnt(s_taken_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest queued expectation.
   initial begin : monitor
      exp_t        e;
      bit          cnt_pending;
      logic [15:0] cnt_exp;
      cnt_pending = 1'b0;
      cnt_exp     = '0;
      forever begin
         @(negedge clk);
         if (cnt_pending) begin
            chk("taken_cnt", 32'(taken_cnt), 32'(cnt_exp));
            cnt_pending = 1'b0;
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("taken", 32'(taken), 32'(e.taken));
               chk("err", 32'(err), 32'(e.err));
               chk("redirect_valid", 32'(redirect_valid), 32'(e.redir));
               if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
               chk("link_data", link_data, e.link);
               chk("flush_with_done", 32'(flush), 32'd0);
               cnt_pending = 1'b1;
               cnt_exp     = e.cnt;
            end
         end
      end
   end

   task automatic send(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [2:0] f3, input logic jal,
                       input logic jalr, input logic e_taken, input logic e_err,
                       input logic e_redir, input logic [31:0] e_rpc, input logic [31:0] e_link,
                       input logic [15:0] e_cnt, input logic e_enb, input bit junk);
      exp_t e;
      int   n, nflush, ndone;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      e = '{taken: e_taken, err: e_err, redir: e_redir, rpc: e_rpc, link: e_link, cnt: e_cnt};
      sb_q.push_back(e);
      req_valid = 1'b1; req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
      req_fun3 = f3; req_jal = jal; req_jalr = jalr;
      @(posedge clk);
      @(negedge clk);
      chk("cmp_enb", 32'(cmp_enb), 32'(e_enb));
      if (e_enb) begin
         chk("cmp_fun3", 32'(cmp_fun3), 32'(f3));
         chk("cmp_A", cmp_A, rs1);
         chk("cmp_B", cmp_B, rs2);
      end
      if (junk) begin
         req_pc = 32'hDEAD_0000; req_rs1 = ~rs1; req_rs2 = ~rs2; req_imm = 32'h7;
      end else begin
         req_valid = 1'b0;
      end
      n = 1; nflush = 0; ndone = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 2) req_valid = 1'b0;
         if (flush) nflush++;
         if (done) ndone = n;
      end
      chk("done_cycle", 32'(ndone), 32'd2);
      chk("ready_cycle", 32'(n), e_redir ? 32'(3 + F) : 32'd3);
      chk("flush_cycles", 32'(nflush), e_redir ? 32'(F) : 32'd0);
   endtask

   task automatic chk_reset();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_taken", 32'(taken), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_cmp_enb", 32'(cmp_enb), 32'd0);
      chk("rst_cmp_A", cmp_A, 32'd0);
      chk("rst_cmp_B", cmp_B, 32'd0);
      chk("rst_cmp_fun3", 32'(cmp_fun3), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_link_data", link_data, 32'd0);
      chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      bit got;
      rst = 1'b1; req_valid = 1'b0; req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
      req_fun3 = '0; req_jal = 1'b0; req_jalr = 1'b0;
      s_req_valid = 1'b0; s_req_pc = '0; s_req_imm = '0; s_req_jal = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      //    pc            imm           rs1           rs2           f3     jal jalr  tk er rd  rpc           link          cnt enb junk
      send(32'h100,      32'h20,       32'h5,        32'h5,        3'b000, 0, 0,   1, 0, 1, 32'h120,      32'h104,      1,  1,  0);
      send(32'h200,      32'h8,        32'h0012_8293,32'hC,        3'b001, 0, 0,   1, 0, 1, 32'h208,      32'h204,      2,  1,  1);
      send(32'h300,      32'h10,       32'hFFFF_FFFF,32'h1,        3'b110, 0, 0,   0, 0, 0, 32'h0,        32'h304,      2,  1,  0);
      send(32'h400,      32'h4,        32'h0,        32'h0,        3'b010, 0, 0,   0, 1, 0, 32'h0,        32'h404,      2,  0,  0);
      send(32'h40,       32'h2,        32'h1001,     32'h0,        3'b000, 0, 1,   1, 1, 0, 32'h0,        32'h44,       2,  0,  0);
      send(32'h40,       32'h3,        32'h1001,     32'h0,        3'b000, 0, 1,   1, 0, 1, 32'h1004,     32'h44,       3,  0,  0);
      send(32'hFFFF_FFFC,32'h8,        32'h0,        32'h0,        3'b011, 1, 0,   1, 0, 1, 32'h4,        32'h0,        4,  0,  0);
      send(32'h500,      32'h10,       32'h3000,     32'h0,        3'b000, 1, 1,   1, 0, 1, 32'h510,      32'h504,      5,  0,  0);
      send(32'h600,      32'hFFFF_FFF8,32'hFFFF_FFFF,32'h1,        3'b100, 0, 0,   1, 0, 1, 32'h5F8,      32'h604,      6,  1,  0);
      send(32'h700,      32'h6,        32'h1,        32'hFFFF_FFFF,3'b101, 0, 0,   1, 1, 0, 32'h0,        32'h704,      6,  1,  0);
      send(32'h780,      32'h6,        32'h1,        32'hFFFF_FFFF,3'b111, 0, 0,   0, 0, 0, 32'h0,        32'h784,      6,  1,  0);

      // Reset inside the flush window: done already happened, count must clear.
      sb_q.push_back('{taken: 1'b1, err: 1'b0, redir: 1'b1, rpc: 32'h840, link: 32'h804, cnt: 16'd7});
      req_valid = 1'b1; req_pc = 32'h800; req_imm = 32'h40; req_rs1 = 32'h7; req_rs2 = 32'h7;
      req_fun3 = 3'b000; req_jal = 1'b0; req_jalr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("flush_window", 32'(flush), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset();
      rst = 1'b0;

      // Reset during EVAL: request is dropped, no done may follow.
      @(negedge clk);
      req_valid = 1'b1; req_pc = 32'h900; req_imm = 32'h10; req_rs1 = 32'h9; req_rs2 = 32'h9;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("eval_cmp_enb", 32'(cmp_enb), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset();
      rst = 1'b0;
      repeat (5) @(negedge clk);

      send(32'hA00, 32'h20, 32'h3, 32'h3, 3'b000, 0, 0, 1, 0, 1, 32'hA20, 32'hA04, 1, 1, 0);

      // Two-bit counter with no flush window saturates at 3.
      for (int i = 0; i < 5; i++) begin
         s_req_pc = 32'(i * 16); s_req_imm = 32'h100; s_req_jal = 1'b1; s_req_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         s_req_valid = 1'b0;
         n = 1; got = 1'b0;
         while (!s_req_ready && n < 20) begin
            @(negedge clk);
            n++;
            if (s_flush) chk("sat_flush", 32'(s_flush), 32'd0);
            if (s_done) begin
               got = 1'b1;
               chk("sat_redirect_valid", 32'(s_redirect_valid), 32'd1);
               chk("sat_redirect_pc", s_redirect_pc, 32'(i * 16 + 256));
               chk("sat_link", s_link_data, 32'(i * 16 + 4));
               chk("sat_taken_err", {30'd0, s_taken, s_err}, 32'd2);
            end
         end
         chk("sat_done_seen", 32'(got), 32'd1);
         chk("sat_ready_cycle", 32'(n), 32'd3);
         chk("sat_cnt", 32'(s_taken_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
